// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types for the initiator and register-slave sides.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } mst_state_t;

  // A zero limit disables the counter but still needs a legal 1-bit vector.
  function automatic int unsigned ctr_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/axi4lite_timeout_ctr.sv
// Clear/enable counter that flags expiry on the LIMIT-th enabled cycle.
module axi4lite_timeout_ctr #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned WIDTH = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // The cycle being counted is included, so expiry fires while count_q is LIMIT-1.
  assign expire = (LIMIT != 0) && en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (LIMIT != 0) && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axi4lite_master_interface.sv
// Single-outstanding AXI4-Lite initiator: command port in, AXI transaction out,
// result back on a response port, with hung-slave timeout and stray-beat counting.
module axi4lite_master_interface
  import axi4lite_pkg::*;
#(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 11,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [7:0]                        stray_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int          DW = C_M_AXI_DATA_WIDTH;
  localparam int          AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned TW = ctr_width(TIMEOUT_CYCLES);

  mst_state_t      state_q, state_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      stray_q, stray_d;
  logic [8:0]      stray_sum;
  logic            aw_done, w_done;
  logic            tmr_clr, tmr_en, tmr_expire;

  assign tmr_en = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_DATA);

  axi4lite_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TW)
  ) u_timeout (
    .clk    (M_AXI_ACLK),
    .rst_n  (M_AXI_ARESETN),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  // Readies are decoded from state; IDLE keeps B/R open so late beats drain.
  assign cmd_ready     = (state_q == IDLE);
  assign M_AXI_BREADY  = (state_q == IDLE) || (state_q == WR_RESP);
  assign M_AXI_RREADY  = (state_q == IDLE) || (state_q == RD_DATA);
  assign rsp_valid     = (state_q == RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;
  assign stray_cnt     = stray_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    stray_d   = stray_q;
    tmr_clr   = 1'b0;
    aw_done   = !awvalid_q || M_AXI_AWREADY;
    w_done    = !wvalid_q || M_AXI_WREADY;
    stray_sum = {1'b0, stray_q} + {8'd0, M_AXI_BVALID} + {8'd0, M_AXI_RVALID};

    case (state_q)
      IDLE: begin
        stray_d = stray_sum[8] ? 8'hFF : stray_sum[7:0];
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          tmr_clr = 1'b1;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (aw_done && w_done) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d    = M_AXI_BRESP;
          rdata_d   = '0;
          timeout_d = 1'b0;
          state_d   = RSP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          resp_d    = M_AXI_RRESP;
          rdata_d   = M_AXI_RDATA;
          timeout_d = 1'b0;
          state_d   = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Expiry overrides any handshake landing on the same edge; a late beat becomes stray.
    if (tmr_expire) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      resp_d    = SLVERR;
      rdata_d   = '0;
      timeout_d = 1'b1;
      state_d   = RSP;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
      stray_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      stray_q   <= stray_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_master_interface.sv
// Directed bench: behavioural AXI4-Lite slave, response scoreboard checked by a
// separate monitor, plus timing, timeout, stray-count and mid-transaction reset checks.
module tb_axi4lite_master_interface;

  localparam int DW = 32;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [7:0]    stray_cnt;

  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, arvalid, bready, rready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic          bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  // Slave behaviour knobs and observation counters
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  bit          aw_never = 0, w_never = 0, ar_never = 0;
  bit          inject_b = 0, inject_r = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  int          aw_hi = 0, w_hi = 0, b_beats = 0, r_beats = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  axi4lite_master_interface #(
    .C_M_AXI_DATA_WIDTH (DW),
    .C_M_AXI_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .stray_cnt     (stray_cnt),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Slave: handshakes sampled mid-cycle, outputs updated 1 time unit after each edge.
  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit aw_got, w_got, b_pend, r_pend;
    int aw_age, w_age, ar_age, r_wait;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_age = 0; w_age = 0; ar_age = 0; r_wait = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (b_hs)    b_beats++;
      if (r_hs)    r_beats++;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_age = 0; w_age = 0; ar_age = 0; r_wait = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      end else begin
        if (b_hs) b_pend = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got = 1;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_pend = 1;
        end
        if (r_hs) r_pend = 0;
        if (ar_hs) begin
          r_pend = 1; r_wait = r_delay;
        end
        if (awvalid) begin awready = !aw_never && (aw_age >= aw_delay); aw_age++; end
        else begin awready = 0; aw_age = 0; end
        if (wvalid) begin wready = !w_never && (w_age >= w_delay); w_age++; end
        else begin wready = 0; w_age = 0; end
        if (arvalid) begin arready = !ar_never && (ar_age >= ar_delay); ar_age++; end
        else begin arready = 0; ar_age = 0; end
        bvalid = b_pend || inject_b;
        bresp  = b_resp_cfg;
        if (r_pend && r_wait > 0) begin
          r_wait--;
          rvalid = inject_r;
        end else begin
          rvalid = r_pend || inject_r;
        end
        rresp = r_resp_cfg;
        rdata = r_pend ? r_data_cfg : '0;
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rdata=%h resp=%0d timeout=%0b, required no response",
                   rsp_rdata, rsp_resp, rsp_timeout);
        end else begin
          e = sb[0];
          chk("rsp_payload", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'({e.rdata, e.resp, e.to}));
          if (rsp_ready) begin
            void'(sb.pop_front());
            $display("txn: rdata=%h resp=%0d timeout=%0b", rsp_rdata, rsp_resp, rsp_timeout);
          end
        end
      end
    end
  end

  task automatic clr_counts();
    aw_hi = 0; w_hi = 0; b_beats = 0; r_beats = 0;
  endtask

  // Returns at 2 time units into the cycle after the acceptance edge.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit push, input logic [31:0] erd,
                        input logic [1:0] ers, input logic eto);
    exp_t e;
    bit acc;
    acc = 0;
    if (push) begin
      e.rdata = erd; e.resp = ers; e.to = eto;
      sb.push_back(e);
    end
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL cmd_accept: cmd_ready=0 for 50 cycles, required 1");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_empty(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic inject(input bit b, input bit r, input int n);
    inject_b = b; inject_r = r;
    repeat (n) @(posedge clk);
    #2;
    inject_b = 0; inject_r = 0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, rsp_valid}), 64'(0));
    chk("rst_readies", 64'({cmd_ready, bready, rready}), 64'(3'b111));
    chk("rst_payload", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'(0));
    chk("rst_stray", 64'(stray_cnt), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Zero-wait write
    clr_counts();
    do_cmd(1'b1, 11'h004, 32'hDEADBEEF, 4'hF, 1, 32'h0, 2'b00, 1'b0);
    chk("zw_awvalid", 64'({awvalid, wvalid}), 64'(2'b11));
    chk("zw_awaddr", 64'(awaddr), 64'(11'h004));
    chk("zw_wdata", 64'({wdata, wstrb}), 64'({32'hDEADBEEF, 4'hF}));
    chk("zw_prot", 64'({awprot, arprot}), 64'(0));
    @(posedge clk); #2;
    chk("zw_n2_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #2;
    chk("zw_n3_rsp_valid", 64'(rsp_valid), 64'(1));
    wait_empty("zw_done");
    chk("zw_counts", 64'({8'(aw_hi), 8'(w_hi), 8'(b_beats)}), 64'({8'd1, 8'd1, 8'd1}));

    // Skewed write: AW ready after 3 wait cycles, W immediate
    clr_counts();
    aw_delay = 3;
    do_cmd(1'b1, 11'h008, 32'hCAFEF00D, 4'h5, 1, 32'h0, 2'b00, 1'b0);
    wait_empty("skew_done");
    chk("skew_aw_hi", 64'(aw_hi), 64'(4));
    chk("skew_w_hi", 64'(w_hi), 64'(1));
    chk("skew_b_beats", 64'(b_beats), 64'(1));
    aw_delay = 0;

    // Read with 2 wait cycles and a stalled response port
    clr_counts();
    rsp_ready = 1'b0;
    r_delay = 2;
    r_data_cfg = 32'h12345678;
    do_cmd(1'b0, 11'h010, 32'h0, 4'h0, 1, 32'h12345678, 2'b00, 1'b0);
    chk("rd_ar", 64'({arvalid, araddr}), 64'({1'b1, 11'h010}));
    n = 0;
    while (n < 20 && !rsp_valid) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rd_latency", 64'(n), 64'(4));
    repeat (5) @(posedge clk);
    #2;
    chk("rd_held_valid", 64'(rsp_valid), 64'(1));
    chk("rd_held_rdata", 64'(rsp_rdata), 64'(32'h12345678));
    rsp_ready = 1'b1;
    wait_empty("rd_done");
    chk("rd_r_beats", 64'(r_beats), 64'(1));
    r_delay = 0;

    // Slave error on read, decode error on write
    r_resp_cfg = 2'b10;
    r_data_cfg = 32'h0BAD0BAD;
    do_cmd(1'b0, 11'h014, 32'h0, 4'h0, 1, 32'h0BAD0BAD, 2'b10, 1'b0);
    wait_empty("rd_err_done");
    r_resp_cfg = 2'b00;
    b_resp_cfg = 2'b11;
    do_cmd(1'b1, 11'h7F0, 32'h55AA55AA, 4'hC, 1, 32'h0, 2'b11, 1'b0);
    wait_empty("wr_decerr_done");
    b_resp_cfg = 2'b00;

    // Timeout with AW and W never accepted
    clr_counts();
    aw_never = 1; w_never = 1;
    do_cmd(1'b1, 11'h020, 32'h11112222, 4'hF, 1, 32'h0, 2'b10, 1'b1);
    wait_empty("to_done");
    chk("to_aw_hi", 64'(aw_hi), 64'(16));
    chk("to_w_hi", 64'(w_hi), 64'(16));
    chk("to_b_beats", 64'(b_beats), 64'(0));
    aw_never = 0; w_never = 0;

    // Stray beats in IDLE: single, simultaneous B+R, saturation
    chk("stray_pre", 64'(stray_cnt), 64'(0));
    inject(1, 0, 1);
    chk("stray_one", 64'(stray_cnt), 64'(1));
    inject(1, 1, 1);
    chk("stray_double", 64'(stray_cnt), 64'(3));
    inject(1, 1, 130);
    chk("stray_sat", 64'(stray_cnt), 64'(255));

    // Reset while ARVALID is high
    ar_never = 1;
    do_cmd(1'b0, 11'h030, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0);
    chk("rr_arvalid_pre", 64'(arvalid), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rr_arvalid_async", 64'(arvalid), 64'(0));
    chk("rr_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rr_stray", 64'(stray_cnt), 64'(0));
    ar_never = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    clr_counts();
    do_cmd(1'b1, 11'h7FC, 32'hA5A55A5A, 4'h3, 1, 32'h0, 2'b00, 1'b0);
    wait_empty("rr_wr_done");
    chk("rr_b_beats", 64'(b_beats), 64'(1));
    chk("rr_stray_post", 64'(stray_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
